// File: rtl/row_max3_stream.sv
// rtl/row_max3_stream.sv - streaming 3-tap horizontal max filter with edge replication
module row_max3_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sol,
    input  logic                  s_eol,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sol,
    output logic                  m_eol,
    output logic                  err_sol
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] cur;
    // Set when the current line entered FLUSH straight from IDLE (one pixel long),
    // so the flushed pixel is both first and last of its line.
    logic                  single;

    logic                  slot_free;
    logic                  accept;
    logic                  in_line;
    logic                  restart;
    logic [DATA_WIDTH-1:0] max_pc;
    logic [DATA_WIDTH-1:0] max_cd;
    logic [DATA_WIDTH-1:0] max_pcd;

    function automatic logic [DATA_WIDTH-1:0] max2(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // The output register can take a new pixel when empty or being drained this cycle.
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = slot_free && (state != FLUSH);
    assign accept    = s_valid && s_ready;
    assign in_line   = (state == FIRST) || (state == RUN);
    // A beat starts a new line from IDLE, or when s_sol interrupts a line in progress.
    assign restart   = accept && ((state == IDLE) || (in_line && s_sol));

    // Window maxima: left edge uses (cur, new), interior uses all three, flush uses (prev, cur).
    always_comb begin
        max_pc  = max2(prev, cur);
        max_cd  = max2(cur, s_data);
        max_pcd = max2(max_pc, s_data);
    end

    // Line-tracking state machine with the registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            prev    <= '0;
            cur     <= '0;
            single  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sol   <= 1'b0;
            m_eol   <= 1'b0;
            err_sol <= 1'b0;
        end else begin
            // A transferred pixel leaves the register unless replaced below.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                FLUSH: begin
                    if (slot_free) begin
                        m_valid <= 1'b1;
                        m_data  <= max_pc;
                        m_sol   <= single;
                        m_eol   <= 1'b1;
                        single  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    if (restart) begin
                        // The pending centre pixel of an interrupted line is dropped.
                        if (state != IDLE) begin
                            err_sol <= 1'b1;
                        end
                        prev   <= s_data;
                        cur    <= s_data;
                        single <= s_eol;
                        state  <= s_eol ? FLUSH : FIRST;
                    end else if (accept) begin
                        m_valid <= 1'b1;
                        m_data  <= (state == FIRST) ? max_cd : max_pcd;
                        m_sol   <= (state == FIRST);
                        m_eol   <= 1'b0;
                        prev    <= cur;
                        cur     <= s_data;
                        single  <= 1'b0;
                        state   <= s_eol ? FLUSH : RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_max3_stream.sv
// tb/tb_row_max3_stream.sv - self-checking bench for row_max3_stream
module tb_row_max3_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_sol;
    logic         s_eol;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_sol;
    logic         m_eol;
    logic         err_sol;

    int checks = 0;
    int passes = 0;

    logic [9:0]   exp_q[$];
    logic [9:0]   obs_q[$];
    logic [W-1:0] line_q[$];
    logic         exp_err;

    logic rdy_mode;
    logic rdy_fixed;
    logic rnd_ready;

    assign m_ready = rdy_mode ? rnd_ready : rdy_fixed;

    always #5 clk = ~clk;

    row_max3_stream #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sol   (s_sol),
        .s_eol   (s_eol),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sol   (m_sol),
        .m_eol   (m_eol),
        .err_sol (err_sol)
    );

    // Random downstream readiness, about 75% of cycles.
    always @(posedge clk) begin
        #1;
        rnd_ready <= ($urandom_range(0, 3) != 0);
    end

    // Record every output transfer that the next rising edge will complete.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            obs_q.push_back({m_sol, m_eol, m_data});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: max over the clamped 3-pixel neighbourhood of pixel i.
    function automatic logic [W-1:0] win_max(input int i);
        int           n;
        logic [W-1:0] a, b, c, m;
        n = line_q.size();
        a = line_q[(i > 0) ? i - 1 : 0];
        b = line_q[i];
        c = line_q[(i < n - 1) ? i + 1 : n - 1];
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    task automatic emit(input int last_idx, input bit complete);
        int n;
        n = line_q.size();
        for (int i = 0; i <= last_idx; i++) begin
            exp_q.push_back({(i == 0), (complete && (i == n - 1)), win_max(i)});
        end
    endtask

    task automatic model_beat(input logic [W-1:0] d, input bit sol, input bit eol);
        if (line_q.size() > 0 && sol) begin
            emit(line_q.size() - 2, 1'b0);
            exp_err = 1'b1;
            line_q.delete();
        end
        line_q.push_back(d);
        if (eol) begin
            emit(line_q.size() - 1, 1'b1);
            line_q.delete();
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit sol, input bit eol);
        int n;
        n = 0;
        model_beat(d, sol, eol);
        s_valid = 1'b1;
        s_data  = d;
        s_sol   = sol;
        s_eol   = eol;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sol   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        int lim;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
        end
        chk({tag, "_err_sol"}, {31'b0, err_sol}, {31'b0, exp_err});
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_sol     = 1'b0;
        s_eol     = 1'b0;
        rdy_mode  = 1'b0;
        rdy_fixed = 1'b1;
        exp_err   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", {24'b0, m_data}, 32'd0);
        chk("rst_m_sol", {31'b0, m_sol}, 32'd0);
        chk("rst_m_eol", {31'b0, m_eol}, 32'd0);
        chk("rst_err_sol", {31'b0, err_sol}, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Line [3,9,1,4] with one-cycle s_ready bubble at flush
        send(8'd3, 1'b1, 1'b0);
        send(8'd9, 1'b0, 1'b0);
        send(8'd1, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b1);
        chk("flush_bubble", {31'b0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("after_flush_ready", {31'b0, s_ready}, 32'd1);
        chk("flush_data", {22'b0, m_eol, m_valid, m_data}, {22'b0, 1'b1, 1'b1, 8'd4});
        drain("line1");

        // Single-pixel line
        send(8'd7, 1'b1, 1'b1);
        drain("one_pix");

        // Back-to-back 2- and 3-pixel lines
        send(8'd5, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b1);
        send(8'd0, 1'b1, 1'b0);
        send(8'd255, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b1);
        drain("b2b");

        // Backpressure mid-line
        send(8'd10, 1'b1, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        rdy_fixed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_m_valid", {31'b0, m_valid}, 32'd1);
            chk("bp_m_data", {24'b0, m_data}, 32'd30);
            chk("bp_s_ready", {31'b0, s_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        send(8'd40, 1'b0, 1'b0);
        send(8'd50, 1'b0, 1'b0);
        send(8'd60, 1'b0, 1'b1);
        drain("bp");

        // Reset after two pixels of [1,2,3]
        rdy_fixed = 1'b0;
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        rst_n = 1'b1;
        line_q.delete();
        exp_err   = 1'b0;
        rdy_fixed = 1'b1;
        send(8'd8, 1'b1, 1'b0);
        send(8'd6, 1'b0, 1'b1);
        drain("post_rst");

        // s_sol mid-line
        send(8'd4, 1'b1, 1'b0);
        send(8'd5, 1'b0, 1'b0);
        send(8'd6, 1'b1, 1'b0);
        send(8'd7, 1'b0, 1'b1);
        drain("sol_err");

        // Randomized lines under random backpressure; err_sol must stay sticky
        rdy_mode = 1'b1;
        for (int l = 0; l < 40; l++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int p = 0; p < len; p++) begin
                logic [W-1:0] d;
                bit           sol;
                d   = W'($urandom_range(0, 255));
                sol = (p == 0) || ($urandom_range(0, 9) == 0);
                send(d, sol, p == len - 1);
            end
        end
        rdy_mode = 1'b0;
        rdy_fixed = 1'b1;
        drain("random");

        // Only reset clears err_sol
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("err_cleared", {31'b0, err_sol}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
